// File: rtl/simon_pkg.sv
// Shared definitions for the colour-memory game core and the LCD message decoder.
package simon_pkg;

    // Internal FSM states of the game core.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_GAP = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_e;

    // Status codes exported on state_o; the LCD controller uses them as message select.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHOW  = 3'd1;
    localparam logic [2:0] ST_INPUT = 3'd2;
    localparam logic [2:0] ST_WIN   = 3'd3;
    localparam logic [2:0] ST_LOSE  = 3'd4;

    // Ceiling log2 for sizing; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Collapse the internal state into the coarse status code.
    function automatic logic [2:0] status_code(input state_e s);
        case (s)
            S_IDLE:                        return ST_IDLE;
            S_ADD, S_SHOW_ON, S_SHOW_GAP:  return ST_SHOW;
            S_WAIT_IN:                     return ST_INPUT;
            S_WIN:                         return ST_WIN;
            S_LOSE:                        return ST_LOSE;
            default:                       return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_color.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) with reduction to a colour index.
module lfsr_color
    import simon_pkg::*;
#(
    parameter int          NUM_COLORS = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         CW         = (clog2(NUM_COLORS) > 1) ? clog2(NUM_COLORS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] color_o
);

    localparam logic [CW:0]   NC_EXT   = NUM_COLORS[CW:0];
    localparam logic [CW-1:0] NC_TRUNC = NUM_COLORS[CW-1:0];

    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_d;
    logic [CW-1:0] raw;

    // Shift left and feed the tap XOR back into bit 0.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR register; advances every clock, independent of the tick enable.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign raw = lfsr_q[CW-1:0];

    // Fold out-of-range draws back into range; one subtraction suffices since raw < 2*NUM_COLORS.
    // NOTE: the output gets a default before the condition so no latch is inferred.
    always_comb begin
        color_o = raw;
        if ({1'b0, raw} >= NC_EXT) begin
            color_o = raw - NC_TRUNC;
        end
    end

endmodule

// File: rtl/simon_seq_engine.sv
// Colour-memory game core: grows a random sequence, plays it back, then checks the echo.
module simon_seq_engine
    import simon_pkg::*;
#(
    parameter int          NUM_COLORS    = 4,
    parameter int          MAX_LEN       = 16,
    parameter int          SHOW_TICKS    = 50,
    parameter int          GAP_TICKS     = 20,
    parameter int          TIMEOUT_TICKS = 100,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    localparam int         CW            = (clog2(NUM_COLORS) > 1) ? clog2(NUM_COLORS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          start,
    input  logic          btn_valid,
    input  logic [CW-1:0] btn_color,
    output logic          show_valid,
    output logic [CW-1:0] show_color,
    output logic          buzzer,
    output logic [7:0]    score,
    output logic [2:0]    state_o,
    output logic          game_over
);

    localparam int IW    = (clog2(MAX_LEN) > 1) ? clog2(MAX_LEN) : 1;
    localparam int MAXT0 = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int MAXT  = (MAXT0 > TIMEOUT_TICKS) ? MAXT0 : TIMEOUT_TICKS;
    localparam int TW    = (clog2(MAXT + 1) > 1) ? clog2(MAXT + 1) : 1;

    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0] GAP_LIM   = TW'(GAP_TICKS);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CW:0]   NC_EXT    = NUM_COLORS[CW:0];

    state_e        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    score_q, score_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] seq_q [MAX_LEN];
    logic          seq_we;
    logic [CW-1:0] new_color;
    logic          idx_last;
    logic          btn_bad;

    logic          show_valid_q, show_valid_d;
    logic [CW-1:0] show_color_q, show_color_d;
    logic          buzzer_q, buzzer_d;
    logic [2:0]    state_code_q;
    logic          game_over_q, game_over_d;

    lfsr_color #(
        .NUM_COLORS (NUM_COLORS),
        .LFSR_SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (reset),
        .color_o (new_color)
    );

    assign idx_last = (8'(idx_q) + 8'd1 == len_q);
    assign btn_bad  = ({1'b0, btn_color} >= NC_EXT) || (btn_color != seq_q[idx_q]);

    // Next-state logic: FSM transitions, sequence pointers, score and duration counter.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        seq_we  = 1'b0;

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (state_q == S_LOSE && tick && cnt_q < GAP_LIM) begin
                    cnt_d = cnt_q + TW'(1);
                end
                if (start) begin
                    state_d = S_ADD;
                    len_d   = 8'd0;
                    score_d = 8'd0;
                    idx_d   = '0;
                end
            end
            S_ADD: begin
                seq_we  = 1'b1;
                len_d   = len_q + 8'd1;
                idx_d   = '0;
                state_d = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (tick) begin
                    cnt_d = cnt_q + TW'(1);
                    if (cnt_q == SHOW_LAST) begin
                        state_d = S_SHOW_GAP;
                    end
                end
            end
            S_SHOW_GAP: begin
                if (tick) begin
                    cnt_d = cnt_q + TW'(1);
                    if (cnt_q == GAP_LAST) begin
                        if (idx_last) begin
                            idx_d   = '0;
                            state_d = S_WAIT_IN;
                        end else begin
                            idx_d   = idx_q + IW'(1);
                            state_d = S_SHOW_ON;
                        end
                    end
                end
            end
            S_WAIT_IN: begin
                if (tick) begin
                    cnt_d = cnt_q + TW'(1);
                end
                // A press wins over a timeout reached on the same cycle.
                if (btn_valid) begin
                    if (btn_bad) begin
                        state_d = S_LOSE;
                    end else if (idx_last) begin
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        state_d = (len_q == MAX_LEN_B) ? S_WIN : S_ADD;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        cnt_d = '0;
                    end
                end else if (tick && cnt_q == TO_LAST) begin
                    state_d = S_LOSE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Output decode from next-state values so every output is a flop.
    always_comb begin
        show_valid_d = (state_d == S_SHOW_ON);
        show_color_d = '0;
        if (state_d == S_SHOW_ON) begin
            // Bypass the element being written this cycle (first element of a new game).
            if (seq_we && len_q[IW-1:0] == idx_d) begin
                show_color_d = new_color;
            end else begin
                show_color_d = seq_q[idx_d];
            end
        end
        buzzer_d    = (state_d == S_SHOW_ON) || (state_d == S_LOSE && cnt_d < GAP_LIM);
        game_over_d = (state_d == S_WIN) || (state_d == S_LOSE);
    end

    // FSM state, pointers, score and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= 8'd0;
            idx_q   <= '0;
            score_q <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sequence storage; appended one element per ADD cycle.
    // NOTE: the array is reset because a mid-game reset must leave no stale sequence behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seq_q[i] <= '0;
            end
        end else if (seq_we) begin
            seq_q[len_q[IW-1:0]] <= new_color;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            show_valid_q <= 1'b0;
            show_color_q <= '0;
            buzzer_q     <= 1'b0;
            state_code_q <= ST_IDLE;
            game_over_q  <= 1'b0;
        end else begin
            show_valid_q <= show_valid_d;
            show_color_q <= show_color_d;
            buzzer_q     <= buzzer_d;
            state_code_q <= status_code(state_d);
            game_over_q  <= game_over_d;
        end
    end

    assign show_valid = show_valid_q;
    assign show_color = show_color_q;
    assign buzzer     = buzzer_q;
    assign score      = score_q;
    assign state_o    = state_code_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Directed bench for simon_seq_engine: a 4-colour instance and a 3-colour instance.
module tb_simon_seq_engine;

    localparam int MAX_LEN       = 3;
    localparam int SHOW_TICKS    = 2;
    localparam int GAP_TICKS     = 1;
    localparam int TIMEOUT_TICKS = 5;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       tick  = 1'b1;

    logic       start_a = 1'b0, btn_valid_a = 1'b0;
    logic [1:0] btn_color_a = 2'd0;
    logic       show_valid_a, buzzer_a, game_over_a;
    logic [1:0] show_color_a;
    logic [7:0] score_a;
    logic [2:0] state_a;

    logic       start_b = 1'b0, btn_valid_b = 1'b0;
    logic [1:0] btn_color_b = 2'd0;
    logic       show_valid_b, buzzer_b, game_over_b;
    logic [1:0] show_color_b;
    logic [7:0] score_b;
    logic [2:0] state_b;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [15:0] m_lfsr;
    logic [1:0] exp_a [MAX_LEN];
    int         alen;
    logic [1:0] c;

    always #5 clk = ~clk;

    simon_seq_engine #(
        .NUM_COLORS(4), .MAX_LEN(MAX_LEN), .SHOW_TICKS(SHOW_TICKS),
        .GAP_TICKS(GAP_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS), .LFSR_SEED(16'hACE1)
    ) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .start(start_a),
        .btn_valid(btn_valid_a), .btn_color(btn_color_a),
        .show_valid(show_valid_a), .show_color(show_color_a), .buzzer(buzzer_a),
        .score(score_a), .state_o(state_a), .game_over(game_over_a)
    );

    simon_seq_engine #(
        .NUM_COLORS(3), .MAX_LEN(MAX_LEN), .SHOW_TICKS(SHOW_TICKS),
        .GAP_TICKS(GAP_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS), .LFSR_SEED(16'hACE1)
    ) dut_b (
        .clk(clk), .reset(reset), .tick(tick), .start(start_b),
        .btn_valid(btn_valid_b), .btn_color(btn_color_b),
        .show_valid(show_valid_b), .show_color(show_color_b), .buzzer(buzzer_b),
        .score(score_b), .state_o(state_b), .game_over(game_over_b)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11, shift left, feedback into bit 0.
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [1:0] draw(input logic [15:0] s, input int n);
        int r;
        r = int'(s[1:0]);
        if (r >= n) r = r - n;
        return 2'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called during an ADD cycle: record the colour being appended.
    task automatic add_a();
        check("a_add_state", state_a, 3'd1);
        exp_a[alen] = draw(m_lfsr, 4);
        alen++;
    endtask

    task automatic start_game_a();
        alen = 0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        add_a();
    endtask

    // From the ADD cycle, follow the whole playback into WAIT_IN.
    task automatic replay_a();
        for (int i = 0; i < alen; i++) begin
            for (int k = 0; k < SHOW_TICKS; k++) begin
                step();
                check("a_show_valid", show_valid_a, 1);
                check("a_show_color", show_color_a, exp_a[i]);
                check("a_show_buzzer", buzzer_a, 1);
            end
            for (int k = 0; k < GAP_TICKS; k++) begin
                step();
                check("a_gap_valid", show_valid_a, 0);
                check("a_gap_color", show_color_a, 0);
                check("a_gap_state", state_a, 1);
            end
        end
        step();
        check("a_wait_state", state_a, 2);
    endtask

    task automatic echo_a();
        for (int i = 0; i < alen; i++) begin
            btn_valid_a = 1'b1;
            btn_color_a = exp_a[i];
            step();
            btn_valid_a = 1'b0;
            if (i < alen - 1) check("a_echo_mid_state", state_a, 2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        alen = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state_a, 0);
        check("rst_show_valid", show_valid_a, 0);
        check("rst_show_color", show_color_a, 0);
        check("rst_buzzer", buzzer_a, 0);
        check("rst_score", score_a, 0);
        check("rst_game_over", game_over_a, 0);
        reset = 1'b1;
        step();
        check("idle_hold_a", state_a, 0);
        check("idle_hold_b", state_b, 0);

        // Full winning game on the 4-colour core.
        start_game_a();
        replay_a();
        echo_a();
        check("r1_score", score_a, 1);
        add_a();
        replay_a();
        echo_a();
        check("r2_score", score_a, 2);
        add_a();
        replay_a();
        echo_a();
        check("win_state", state_a, 3);
        check("win_game_over", game_over_a, 1);
        check("win_buzzer", buzzer_a, 0);
        check("win_score", score_a, 3);
        btn_valid_a = 1'b1;
        btn_color_a = exp_a[0];
        step();
        btn_valid_a = 1'b0;
        check("win_press_ignored", state_a, 3);
        check("win_score_hold", score_a, 3);
        start_game_a();
        check("restart_score", score_a, 0);
        check("restart_game_over", game_over_a, 0);

        // Wrong colour in round 2.
        replay_a();
        echo_a();
        check("r1b_score", score_a, 1);
        add_a();
        replay_a();
        btn_valid_a = 1'b1;
        btn_color_a = exp_a[0] ^ 2'b01;
        step();
        btn_valid_a = 1'b0;
        check("lose_state", state_a, 4);
        check("lose_game_over", game_over_a, 1);
        check("lose_buzzer_on", buzzer_a, 1);
        check("lose_score", score_a, 1);
        step();
        check("lose_buzzer_off", buzzer_a, 0);
        repeat (3) step();
        check("lose_hold", state_a, 4);
        check("lose_buzzer_quiet", buzzer_a, 0);

        // Timeout with no press.
        start_game_a();
        replay_a();
        for (int k = 0; k < TIMEOUT_TICKS - 1; k++) begin
            step();
            check("to_wait_state", state_a, 2);
        end
        step();
        check("to_lose_state", state_a, 4);
        check("to_lose_buzzer", buzzer_a, 1);

        // 3-colour core: 1000 short games, each lost with an out-of-range press.
        for (int g = 0; g < 1000; g++) begin
            start_b = 1'b1;
            step();
            start_b = 1'b0;
            check("b_add_state", state_b, 1);
            c = draw(m_lfsr, 3);
            step();
            check("b_show_color", show_color_b, c);
            check("b_show_in_range", show_color_b < 2'd3, 1);
            step();
            step();
            step();
            check("b_wait_state", state_b, 2);
            btn_valid_b = 1'b1;
            btn_color_b = 2'd3;
            step();
            btn_valid_b = 1'b0;
            check("b_bad_color_lose", state_b, 4);
        end

        // Press on the last tick before timeout is accepted.
        start_game_a();
        replay_a();
        for (int k = 0; k < TIMEOUT_TICKS - 1; k++) begin
            step();
            check("late_wait_state", state_a, 2);
        end
        btn_valid_a = 1'b1;
        btn_color_a = exp_a[0];
        start_b = 1'b1;
        step();
        btn_valid_a = 1'b0;
        start_b = 1'b0;
        check("late_press_score", score_a, 1);
        check("b_restart_state", state_b, 1);
        add_a();
        step();
        // start and presses during playback are ignored.
        start_a = 1'b1;
        btn_valid_a = 1'b1;
        btn_color_a = exp_a[0] ^ 2'b10;
        step();
        start_a = 1'b0;
        btn_valid_a = 1'b0;
        check("show_start_ignored", show_valid_a, 1);
        check("show_color_kept", show_color_a, exp_a[0]);
        check("show_score_kept", score_a, 1);
        check("b_show_valid", show_valid_b, 1);

        // Asynchronous reset mid-SHOW_ON clears everything immediately.
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_a_state", state_a, 0);
        check("mid_rst_a_show_valid", show_valid_a, 0);
        check("mid_rst_a_show_color", show_color_a, 0);
        check("mid_rst_a_buzzer", buzzer_a, 0);
        check("mid_rst_a_score", score_a, 0);
        check("mid_rst_a_game_over", game_over_a, 0);
        check("mid_rst_b_state", state_b, 0);
        check("mid_rst_b_show_valid", show_valid_b, 0);
        check("mid_rst_b_show_color", show_color_b, 0);
        check("mid_rst_b_buzzer", buzzer_b, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("post_rst_idle", state_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
